// File: rtl/mem_control_if.sv
// mem_control_if: EX-stage, memory-port and writeback signals of the memory control unit.
interface mem_control_if;
    logic        InValid, RegWriteIn, MemRead, MemWrite, Flush, MemAck;
    logic [4:0]  WriteRegIn, WriteRegOut;
    logic [31:0] ALUResult, StoreData, MemRData, MemAddr, MemWData, WBData;
    logic        MemReq, MemWe, Stall, WBValid, RegWriteOut, MemErr;
    modport master (
        output InValid, RegWriteIn, MemRead, MemWrite, WriteRegIn, ALUResult, StoreData, Flush, MemAck, MemRData,
        input  MemReq, MemWe, MemAddr, MemWData, Stall, WBValid, RegWriteOut, WriteRegOut, WBData, MemErr
    );
    modport slave (
        input  InValid, RegWriteIn, MemRead, MemWrite, WriteRegIn, ALUResult, StoreData, Flush, MemAck, MemRData,
        output MemReq, MemWe, MemAddr, MemWData, Stall, WBValid, RegWriteOut, WriteRegOut, WBData, MemErr
    );
endinterface

// File: rtl/mem_control.sv
// mem_control: MEM stage; passes ALU results through, runs one load/store at a time
// against a request/ack memory port with a bounded wait, and drives writeback.
module mem_control #(
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_control_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d, wbv_q, wbv_d, rw_q, rw_d, err_q, err_d;
    logic        load_q, load_d, prw_q, prw_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wbdata_q, wbdata_d;
    logic        accept, is_mem;
    always_comb begin
        accept   = bus.InValid && !bus.Flush && state_q != ACCESS;
        is_mem   = bus.MemRead || bus.MemWrite;
        state_d  = state_q == ACCESS ? ACCESS : IDLE;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        load_d   = load_q;
        prw_d    = prw_q;
        rd_d     = rd_q;
        wbdata_d = wbdata_q;
        wbv_d    = 1'b0;
        rw_d     = 1'b0;
        err_d    = 1'b0;
        if (state_q == ACCESS) begin
            // ack is checked first so an ack in the final wait cycle still succeeds
            if (bus.MemAck) begin
                state_d  = RESP;
                req_d    = 1'b0;
                we_d     = 1'b0;
                wbv_d    = 1'b1;
                rw_d     = load_q && prw_q;
                wbdata_d = load_q ? bus.MemRData : wbdata_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_d == 8'(TIMEOUT)) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wbv_d   = 1'b1;
                    err_d   = 1'b1;
                end
            end
        end else if (accept) begin
            rd_d  = bus.WriteRegIn;
            wbv_d = !is_mem || bus.ALUResult[1:0] != 2'b00;
            rw_d  = !is_mem && bus.RegWriteIn;
            err_d = is_mem && bus.ALUResult[1:0] != 2'b00;
            wbdata_d = is_mem ? wbdata_q : bus.ALUResult;
            if (is_mem && bus.ALUResult[1:0] == 2'b00) begin
                state_d = ACCESS;
                cnt_d   = 8'd0;
                req_d   = 1'b1;
                we_d    = bus.MemWrite;
                addr_d  = bus.ALUResult;
                wdata_d = bus.MemWrite ? bus.StoreData : wdata_q;
                load_d  = !bus.MemWrite;
                prw_d   = bus.RegWriteIn;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            wbv_q    <= 1'b0;
            rw_q     <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
            prw_q    <= 1'b0;
            rd_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wbdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            wbv_q    <= wbv_d;
            rw_q     <= rw_d;
            err_q    <= err_d;
            load_q   <= load_d;
            prw_q    <= prw_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wbdata_q <= wbdata_d;
        end
    end
    assign bus.MemReq      = req_q;
    assign bus.MemWe       = we_q;
    assign bus.MemAddr     = addr_q;
    assign bus.MemWData    = wdata_q;
    assign bus.Stall       = state_q == ACCESS;
    assign bus.WBValid     = wbv_q;
    assign bus.RegWriteOut = rw_q;
    assign bus.WriteRegOut = rd_q;
    assign bus.WBData      = wbdata_q;
    assign bus.MemErr      = err_q;
endmodule

// File: tb/tb_mem_control.sv
// tb_mem_control: transaction-level reference model checked every cycle, plus directed
// scenarios with literal expectations and a randomized phase.
module tb_mem_control;
    localparam int T = 4;
    logic clk = 1'b0, rst = 1'b1;
    int checks = 0, errors = 0;
    mem_control_if bus();
    mem_control #(.TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // model: at most one outstanding memory access, aged per cycle without ack
    bit          busy = 0, p_load = 0, p_rw = 0;
    int          age = 0;
    bit          exp_wbv = 0, exp_rw = 0, exp_err = 0, exp_we = 0, chk_data = 0;
    logic [4:0]  exp_rd = '0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_data = '0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        exp_wbv = 0; exp_rw = 0; exp_err = 0; chk_data = 0;
        if (rst) begin
            busy = 0; age = 0; exp_we = 0;
        end else if (busy) begin
            if (bus.MemAck) begin
                busy = 0; exp_wbv = 1; exp_rw = p_load && p_rw;
                if (p_load) begin exp_data = bus.MemRData; chk_data = 1; end
            end else begin
                age = age + 1;
                if (age == T) begin busy = 0; exp_wbv = 1; exp_err = 1; end
            end
        end else if (bus.InValid && !bus.Flush) begin
            exp_rd = bus.WriteRegIn;
            if (!(bus.MemRead || bus.MemWrite)) begin
                exp_wbv = 1; exp_rw = bus.RegWriteIn; exp_data = bus.ALUResult; chk_data = 1;
            end else if (bus.ALUResult[1:0] != 2'b00) begin
                exp_wbv = 1; exp_err = 1;
            end else begin
                busy = 1; age = 0; p_load = !bus.MemWrite; p_rw = bus.RegWriteIn;
                exp_addr = bus.ALUResult; exp_we = bus.MemWrite;
                if (bus.MemWrite) exp_wdata = bus.StoreData;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("MemReq", 32'(bus.MemReq), 32'(busy));
        chk("Stall", 32'(bus.Stall), 32'(busy));
        chk("WBValid", 32'(bus.WBValid), 32'(exp_wbv));
        chk("RegWriteOut", 32'(bus.RegWriteOut), 32'(exp_rw));
        chk("MemErr", 32'(bus.MemErr), 32'(exp_err));
        if (busy) begin
            chk("MemAddr", bus.MemAddr, exp_addr);
            chk("MemWe", 32'(bus.MemWe), 32'(exp_we));
            if (exp_we) chk("MemWData", bus.MemWData, exp_wdata);
        end
        if (chk_data) begin
            chk("WBData", bus.WBData, exp_data);
            chk("WriteRegOut", 32'(bus.WriteRegOut), 32'(exp_rd));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.InValid = 0; bus.Flush = 0; bus.MemAck = 0;
    endtask

    task automatic issue(input bit rd, input bit wr, input bit rw, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] d);
        bus.InValid = 1; bus.Flush = 0; bus.MemRead = rd; bus.MemWrite = wr;
        bus.RegWriteIn = rw; bus.WriteRegIn = r; bus.ALUResult = a; bus.StoreData = d;
    endtask

    initial begin
        quiet();
        bus.MemRead = 0; bus.MemWrite = 0; bus.RegWriteIn = 0; bus.WriteRegIn = '0;
        bus.ALUResult = '0; bus.StoreData = '0; bus.MemRData = '0;
        cyc();
        chk("rst MemReq", 32'(bus.MemReq), 0);
        chk("rst Stall", 32'(bus.Stall), 0);
        chk("rst WBValid", 32'(bus.WBValid), 0);
        chk("rst MemAddr", bus.MemAddr, 0);
        chk("rst WBData", bus.WBData, 0);
        chk("rst WriteRegOut", 32'(bus.WriteRegOut), 0);
        rst = 0;
        issue(0, 0, 1, 5'd5, 32'h1234, 0);
        cyc();
        chk("alu WBValid", 32'(bus.WBValid), 1);
        chk("alu RegWriteOut", 32'(bus.RegWriteOut), 1);
        chk("alu WriteRegOut", 32'(bus.WriteRegOut), 5);
        chk("alu WBData", bus.WBData, 32'h1234);
        chk("alu Stall", 32'(bus.Stall), 0);
        issue(1, 0, 1, 5'd7, 32'h100, 0);
        cyc();
        quiet();
        for (int i = 0; i < 3; i++) begin
            chk("ld MemReq", 32'(bus.MemReq), 1);
            chk("ld Stall", 32'(bus.Stall), 1);
            chk("ld MemAddr", bus.MemAddr, 32'h100);
            if (i == 2) begin bus.MemAck = 1; bus.MemRData = 32'hDEADBEEF; end
            cyc();
        end
        bus.MemAck = 0;
        chk("ld WBData", bus.WBData, 32'hDEADBEEF);
        chk("ld RegWriteOut", 32'(bus.RegWriteOut), 1);
        chk("ld Stall resp", 32'(bus.Stall), 0);
        issue(0, 1, 1, 5'd3, 32'h104, 32'hA5A5A5A5);
        cyc();
        quiet();
        bus.MemAck = 1;
        chk("st MemWe", 32'(bus.MemWe), 1);
        chk("st MemWData", bus.MemWData, 32'hA5A5A5A5);
        cyc();
        bus.MemAck = 0;
        chk("st WBValid", 32'(bus.WBValid), 1);
        chk("st RegWriteOut", 32'(bus.RegWriteOut), 0);
        issue(1, 0, 1, 5'd9, 32'h102, 0);
        cyc();
        quiet();
        chk("mis MemErr", 32'(bus.MemErr), 1);
        chk("mis RegWriteOut", 32'(bus.RegWriteOut), 0);
        chk("mis MemReq", 32'(bus.MemReq), 0);
        cyc();
        chk("mis pulse", 32'(bus.MemErr), 0);
        for (int k = 0; k < 2; k++) begin
            issue(1, 0, 1, 5'd11, 32'h200, 0);
            cyc();
            quiet();
            for (int i = 0; i < T; i++) begin
                chk("to MemReq", 32'(bus.MemReq), 1);
                if (k == 1 && i == T - 1) begin bus.MemAck = 1; bus.MemRData = 32'h600D; end
                cyc();
            end
            bus.MemAck = 0;
            chk("to MemErr", 32'(bus.MemErr), k == 0 ? 1 : 0);
            chk("to RegWriteOut", 32'(bus.RegWriteOut), k == 0 ? 0 : 1);
            chk("to MemReq off", 32'(bus.MemReq), 0);
        end
        issue(0, 0, 1, 5'd2, 32'hBEE0, 0);
        cyc();
        quiet();
        chk("resp accept", bus.WBData, 32'hBEE0);
        issue(1, 1, 1, 5'd4, 32'h300, 32'h77);
        cyc();
        quiet();
        chk("both MemWe", 32'(bus.MemWe), 1);
        #2 rst = 1;
        #1 chk("async MemReq", 32'(bus.MemReq), 0);
        chk("async Stall", 32'(bus.Stall), 0);
        cyc();
        rst = 0;
        cyc();
        chk("abort WBValid", 32'(bus.WBValid), 0);
        issue(0, 0, 1, 5'd6, 32'h55, 0);
        bus.Flush = 1;
        cyc();
        quiet();
        chk("flush WBValid", 32'(bus.WBValid), 0);
        for (int n = 0; n < 3000; n++) begin
            rst = $urandom_range(0, 399) == 0;
            bus.InValid = $urandom_range(0, 9) < 7;
            bus.Flush = $urandom_range(0, 9) == 0;
            {bus.MemRead, bus.MemWrite} = 2'($urandom_range(0, 3));
            bus.RegWriteIn = 1'($urandom_range(0, 1));
            bus.WriteRegIn = 5'($urandom_range(0, 31));
            bus.ALUResult = $urandom;
            if ($urandom_range(0, 3) != 0) bus.ALUResult[1:0] = 2'b00;
            bus.StoreData = $urandom;
            bus.MemAck = $urandom_range(0, 3) == 0;
            bus.MemRData = $urandom;
            cyc();
        end
        rst = 0;
        quiet();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
